// File: rtl/axis_register_skid_if.sv
// AXI-Stream bundle for axis_register_skid: payload, qualifiers and the valid/ready pair.
// USER_WIDTH=0 keeps tuser one bit wide so the ports stay legal.
interface axis_register_skid_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int USER_WIDTH = 8
);
  localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1;

  logic [BYTE_WIDTH*8-1:0] tdata;
  logic [BYTE_WIDTH-1:0]   tkeep;
  logic [UW-1:0]           tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  // A beat transfers on a rising edge where tvalid & tready are both 1; the source
  // holds tvalid and the payload steady until that edge, ready may change freely.
  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_register_skid.sv
// Full AXI-Stream register slice: registered forward payload/valid and registered ready.
// Optional stall counter output enabled by `define AXIS_REGISTER_SKID_STALL_CNT_EN.
module axis_register_skid #(
  parameter int BYTE_WIDTH = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  axis_register_skid_if.slave   s_axis,
  axis_register_skid_if.master  m_axis,
  output logic [1:0]            dbg_state
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
  ,
  output logic [31:0]           STALL_COUNT
`endif
);
  localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1;
  localparam int PW = BYTE_WIDTH*8 + BYTE_WIDTH + UW + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] out_pl;
  logic [PW-1:0] skid_pl;
  logic [PW-1:0] in_pl;
  logic [UW-1:0] s_user;
  logic          s_tready_r;
  logic          m_tvalid_r;
  logic          s_hs;
  logic          m_hs;

  assign s_user = (USER_WIDTH == 0) ? '0 : s_axis.tuser;
  assign in_pl  = {s_axis.tlast, s_user, s_axis.tkeep, s_axis.tdata};
  assign s_hs   = s_axis.tvalid & s_tready_r;
  assign m_hs   = m_tvalid_r & m_axis.tready;

  assign s_axis.tready = s_tready_r;
  assign m_axis.tvalid = m_tvalid_r;
  assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = out_pl;
  assign dbg_state = state;

  // Ready and valid are registered alongside the state so each always reflects the
  // state being entered; ready is 0 in reset and rises on the first edge after release.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= EMPTY;
      out_pl     <= '0;
      skid_pl    <= '0;
      s_tready_r <= 1'b0;
      m_tvalid_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          s_tready_r <= 1'b1;
          if (s_hs) begin
            out_pl     <= in_pl;
            state      <= BUSY;
            m_tvalid_r <= 1'b1;
          end else begin
            m_tvalid_r <= 1'b0;
          end
        end
        BUSY: begin
          if (s_hs && m_hs) begin
            out_pl <= in_pl;
          end else if (s_hs) begin
            skid_pl    <= in_pl;
            state      <= FULL;
            s_tready_r <= 1'b0;
          end else if (m_hs) begin
            state      <= EMPTY;
            m_tvalid_r <= 1'b0;
          end
        end
        FULL: begin
          // Upstream is stalled here, so only the downstream handshake matters.
          if (m_hs) begin
            out_pl     <= skid_pl;
            state      <= BUSY;
            s_tready_r <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          s_tready_r <= 1'b0;
          m_tvalid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      STALL_COUNT <= '0;
    end else if (m_tvalid_r && !m_axis.tready && (STALL_COUNT != 32'hFFFF_FFFF)) begin
      STALL_COUNT <= STALL_COUNT + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axis_register_skid.sv
// Directed and random bench for axis_register_skid; a USER_WIDTH=0 copy runs in lockstep.
// Define AXIS_REGISTER_SKID_STALL_CNT_EN to also check the stall counter.
module tb_axis_register_skid;
  localparam int W = 81;  // {tlast, tuser[7:0], tkeep[7:0], tdata[63:0]}

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp0_q[$];
  logic [31:0]  exp_stall = 0;

  axis_register_skid_if #(.BYTE_WIDTH(8), .USER_WIDTH(8)) s_if ();
  axis_register_skid_if #(.BYTE_WIDTH(8), .USER_WIDTH(8)) m_if ();
  axis_register_skid_if #(.BYTE_WIDTH(8), .USER_WIDTH(0)) s_if0 ();
  axis_register_skid_if #(.BYTE_WIDTH(8), .USER_WIDTH(0)) m_if0 ();

  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] stall_count0;
`endif

  axis_register_skid #(.BYTE_WIDTH(8), .USER_WIDTH(8)) dut (
    .CLK(clk), .RESETN(rst_n), .s_axis(s_if), .m_axis(m_if), .dbg_state(dbg_state)
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
    , .STALL_COUNT(stall_count)
`endif
  );

  axis_register_skid #(.BYTE_WIDTH(8), .USER_WIDTH(0)) dut0 (
    .CLK(clk), .RESETN(rst_n), .s_axis(s_if0), .m_axis(m_if0), .dbg_state(dbg_state0)
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
    , .STALL_COUNT(stall_count0)
`endif
  );

  assign s_if0.tdata  = s_if.tdata;
  assign s_if0.tkeep  = s_if.tkeep;
  assign s_if0.tuser  = s_if.tuser[0];
  assign s_if0.tvalid = s_if.tvalid;
  assign s_if0.tlast  = s_if.tlast;
  assign m_if0.tready = m_if.tready;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic [7:0] u, input logic l);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tuser  = u;
    s_if.tlast  = l;
  endtask

  // One clock: scoreboard both DUTs around the edge, then check the AXIS hold rule.
  task automatic tick();
    logic         hold;
    logic [W-1:0] held;
    logic [W-1:0] got;
    logic [W-1:0] got0;
    got  = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
    got0 = {m_if0.tlast, 7'd0, m_if0.tuser, m_if0.tkeep, m_if0.tdata};
    if (m_if.tvalid && m_if.tready) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL sb_w8: got %h, expected nothing", got);
      else if (got !== exp_q[0]) $display("FAIL sb_w8: got %h, expected %h", got, exp_q[0]);
      else n_pass++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (m_if0.tvalid && m_if0.tready) begin
      n_checks++;
      if (exp0_q.size() == 0) $display("FAIL sb_w0: got %h, expected nothing", got0);
      else if (got0 !== exp0_q[0]) $display("FAIL sb_w0: got %h, expected %h", got0, exp0_q[0]);
      else n_pass++;
      if (exp0_q.size() != 0) void'(exp0_q.pop_front());
    end
    if (s_if.tvalid && s_if.tready)
      exp_q.push_back({s_if.tlast, s_if.tuser, s_if.tkeep, s_if.tdata});
    if (s_if0.tvalid && s_if0.tready)
      exp0_q.push_back({s_if.tlast, 8'd0, s_if.tkeep, s_if.tdata});
    if (m_if.tvalid && !m_if.tready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    hold = m_if.tvalid && !m_if.tready;
    held = got;
    @(posedge clk);
    #1;
    if (hold) begin
      n_checks++;
      if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata} !== {1'b1, held})
        $display("FAIL hold_stable: got v=%b %h, expected v=1 %h", m_if.tvalid,
                 {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata}, held);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    m_if.tready = 1'b0;
    drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({m_if.tvalid, s_if.tready, m_if.tdata} !== {1'b0, 1'b0, 64'd0})
      $display("FAIL reset_out: got v=%b r=%b d=%h, expected 0 0 0", m_if.tvalid, s_if.tready, m_if.tdata);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s_if.tready !== 1'b0) $display("FAIL reset_ready_early: got %b, expected 0", s_if.tready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({s_if.tready, m_if.tvalid, dbg_state} !== {1'b1, 1'b0, 2'd0})
      $display("FAIL reset_release: got r=%b v=%b st=%0d, expected 1 0 0", s_if.tready, m_if.tvalid, dbg_state);
    else n_pass++;
  endtask

  task automatic test_streaming();
    m_if.tready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c >= 1) begin
        n_checks++;
        if ({m_if.tvalid, m_if.tdata, m_if.tlast} !== {1'b1, 64'(c - 1), c == 16})
          $display("FAIL stream_beat%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b", c - 1,
                   m_if.tvalid, m_if.tdata, m_if.tlast, 64'(c - 1), c == 16);
        else n_pass++;
      end
      if (c < 16) drive(1'b1, 64'(c), (c == 15) ? 8'h0F : 8'hFF, 8'(c + 8'h40), c == 15);
      else drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
      tick();
    end
    n_checks++;
    if (m_if.tvalid !== 1'b0) $display("FAIL stream_idle: got v=%b, expected 0", m_if.tvalid);
    else n_pass++;
  endtask

  task automatic test_single_stall();
    m_if.tready = 1'b1;
    drive(1'b1, 64'hA, 8'hFF, 8'h0A, 1'b0);
    tick();
    drive(1'b1, 64'hB, 8'hFF, 8'h0B, 1'b1);
    m_if.tready = 1'b0;
    tick();
    n_checks++;
    if ({m_if.tvalid, m_if.tdata, s_if.tready, dbg_state} !== {1'b1, 64'hA, 1'b0, 2'd2})
      $display("FAIL stall_full: got v=%b d=%h r=%b st=%0d, expected 1 a 0 2",
               m_if.tvalid, m_if.tdata, s_if.tready, dbg_state);
    else n_pass++;
    drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
    m_if.tready = 1'b1;
    tick();
    n_checks++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, s_if.tready} !== {1'b1, 64'hB, 1'b1, 1'b1})
      $display("FAIL stall_release: got v=%b d=%h l=%b r=%b, expected 1 b 1 1",
               m_if.tvalid, m_if.tdata, m_if.tlast, s_if.tready);
    else n_pass++;
    tick();
    n_checks++;
    if ({m_if.tvalid, exp_q.size() == 0} !== 2'b01)
      $display("FAIL stall_drain: got v=%b pending=%0d, expected v=0 pending=0", m_if.tvalid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_long_stall();
    logic [63:0] d = 64'h20;
    int          acc = 0;
    m_if.tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, d, 8'hFF, d[7:0], 1'b0);
      if (s_if.tready) begin acc++; d++; end
      tick();
    end
    n_checks++;
    if ({acc, m_if.tdata} !== {32'd2, 64'h20})
      $display("FAIL long_stall: got accepted=%0d d=%h, expected 2 20", acc, m_if.tdata);
    else n_pass++;
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
    n_checks++;
    if (stall_count !== exp_stall) $display("FAIL stall_count: got %0d, expected %0d", stall_count, exp_stall);
    else n_pass++;
`endif
    m_if.tready = 1'b1;
    for (int c = 0; c < 40 && d < 64'h26; c++) begin
      drive(1'b1, d, 8'hFF, d[7:0], d == 64'h25);
      if (s_if.tready) d++;
      tick();
    end
    drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({m_if.tvalid, exp_q.size() == 0, d} !== {1'b0, 1'b1, 64'h26})
      $display("FAIL long_drain: got v=%b pending=%0d next=%h, expected 0 0 26", m_if.tvalid, exp_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (!(s_if.tvalid && !s_if.tready)) begin
        if (sent < 1000 && $urandom_range(1, 0) == 1)
          drive(1'b1, {$urandom, $urandom}, 8'($urandom), 8'($urandom), 1'($urandom));
        else
          drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
      end
      m_if.tready = 1'($urandom_range(1, 0));
      if (s_if.tvalid && s_if.tready) sent++;
      tick();
      cyc++;
    end
    n_checks++;
    if ({sent, exp_q.size(), exp0_q.size()} !== {32'd1000, 32'd0, 32'd0})
      $display("FAIL random_done: got sent=%0d pending=%0d/%0d after %0d cycles, expected 1000 0 0",
               sent, exp_q.size(), exp0_q.size(), cyc);
    else n_pass++;
    drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
    m_if.tready = 1'b1;
    repeat (2) tick();
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
    n_checks++;
    if (stall_count !== exp_stall) $display("FAIL stall_count_rand: got %0d, expected %0d", stall_count, exp_stall);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_full();
    m_if.tready = 1'b1;
    drive(1'b1, 64'hC1, 8'hFF, 8'hC1, 1'b0);
    tick();
    m_if.tready = 1'b0;
    drive(1'b1, 64'hC2, 8'hFF, 8'hC2, 1'b1);
    tick();
    n_checks++;
    if (dbg_state !== 2'd2) $display("FAIL rst_full_setup: got st=%0d, expected 2", dbg_state);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_if.tvalid, s_if.tready, m_if.tdata, dbg_state} !== {1'b0, 1'b0, 64'd0, 2'd0})
      $display("FAIL rst_async: got v=%b r=%b d=%h st=%0d, expected 0 0 0 0",
               m_if.tvalid, s_if.tready, m_if.tdata, dbg_state);
    else n_pass++;
`ifdef AXIS_REGISTER_SKID_STALL_CNT_EN
    n_checks++;
    if (stall_count !== 32'd0) $display("FAIL rst_stall_count: got %0d, expected 0", stall_count);
    else n_pass++;
    exp_stall = 0;
`endif
    exp_q.delete();
    exp0_q.delete();
    drive(1'b0, 64'd0, 8'd0, 8'd0, 1'b0);
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (m_if.tvalid !== 1'b0) $display("FAIL rst_no_ghost: got v=%b d=%h at cycle %0d, expected 0",
                                         m_if.tvalid, m_if.tdata, c);
      else n_pass++;
      tick();
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_streaming();
    test_single_stall();
    test_long_stall();
    test_random();
    test_reset_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
